// File: rtl/cnt_led_pkg.sv
// rtl/cnt_led_pkg.sv - shared types and helpers for the counter/LED display block
package cnt_led_pkg;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_WAIT_PRESS,
    DB_PRESSED,
    DB_WAIT_REL
  } db_state_t;

  // Largest legal shift keeps the OUT_W-bit window inside the counter.
  function automatic int unsigned clamp_shift(input int unsigned sel,
                                              input int unsigned cnt_w,
                                              input int unsigned out_w);
    int unsigned max_shift;
    max_shift = cnt_w - out_w;
    return (sel > max_shift) ? max_shift : sel;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-FF synchroniser plus press/release debouncer for one active-low key
module key_debounce
  import cnt_led_pkg::*;
#(
  parameter int DB_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press_pulse,
  output logic pressed
);

  localparam int TW = (DB_CYC > 2) ? $clog2(DB_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(DB_CYC - 2);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [1:0]    flush_q, flush_d;
  logic          armed_q, armed_d;
  db_state_t     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    sync1_d     = key_n;
    sync2_d     = sync1_q;
    flush_d     = (flush_q == 2'd2) ? flush_q : flush_q + 2'd1;
    // A key held through reset must be seen released before a press counts.
    armed_d     = armed_q | ((flush_q == 2'd2) && sync2_q);
    state_d     = state_q;
    timer_d     = timer_q;
    press_pulse = 1'b0;
    case (state_q)
      DB_IDLE: begin
        if (armed_q && !sync2_q) begin
          state_d = DB_WAIT_PRESS;
          timer_d = '0;
        end
      end
      DB_WAIT_PRESS: begin
        if (sync2_q) begin
          state_d = DB_IDLE;
        end else if (timer_q == T_LAST) begin
          state_d     = DB_PRESSED;
          press_pulse = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DB_PRESSED: begin
        if (sync2_q) begin
          state_d = DB_WAIT_REL;
          timer_d = '0;
        end
      end
      DB_WAIT_REL: begin
        if (!sync2_q) begin
          state_d = DB_PRESSED;
        end else if (timer_q == T_LAST) begin
          state_d = DB_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = DB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      flush_q <= 2'd0;
      armed_q <= 1'b0;
      state_q <= DB_IDLE;
      timer_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      flush_q <= flush_d;
      armed_q <= armed_d;
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  assign pressed = (state_q == DB_PRESSED) || (state_q == DB_WAIT_REL);

endmodule

// File: rtl/cnt_led_disp.sv
// rtl/cnt_led_disp.sv - debounced up/down counter with windowed active-low LED output
// Optional prescaler enabled by defining CNT_LED_PRESCALE_EN.
module cnt_led_disp
  import cnt_led_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int OUT_W   = 16,
  parameter int SEL_W   = 4,
  parameter int DB_CYC  = 500000,
  parameter int PRE_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_run_n,
  input  logic             key_clr_n,
  input  logic             key_dir_n,
  input  logic [SEL_W-1:0] sel_n,
  output logic [OUT_W-1:0] led_n,
  output logic             running,
  output logic             dir_down
);

  logic run_pulse, run_level;
  logic clr_pulse, clr_level;
  logic dir_pulse, dir_level;
  logic unused_levels;

  key_debounce #(.DB_CYC(DB_CYC)) u_run (
    .clk(clk), .rst(rst), .key_n(key_run_n), .press_pulse(run_pulse), .pressed(run_level)
  );
  key_debounce #(.DB_CYC(DB_CYC)) u_clr (
    .clk(clk), .rst(rst), .key_n(key_clr_n), .press_pulse(clr_pulse), .pressed(clr_level)
  );
  key_debounce #(.DB_CYC(DB_CYC)) u_dir (
    .clk(clk), .rst(rst), .key_n(key_dir_n), .press_pulse(dir_pulse), .pressed(dir_level)
  );

  assign unused_levels = run_level ^ dir_level ^ clr_pulse;

  logic             running_q, running_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] win_q, win_d;
  logic [SEL_W-1:0] sel_inv;
  int unsigned      shift;
  logic             step;

  assign sel_inv = ~sel_n;
  assign shift   = clamp_shift(32'(sel_inv), CNT_W, OUT_W);

`ifdef CNT_LED_PRESCALE_EN
  localparam int PW = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          pre_tick;

  assign pre_tick = (pre_q == PRE_LAST);
  assign pre_d    = (clr_level || pre_tick) ? '0 : pre_q + PW'(1);
  assign step     = running_q && pre_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pre_q <= '0;
    else      pre_q <= pre_d;
  end
`else
  localparam int unused_pre_div = PRE_DIV;
  assign step = running_q;
`endif

  always_comb begin
    running_d = running_q ^ run_pulse;
    dir_d     = dir_q ^ dir_pulse;
    cnt_d     = cnt_q;
    // Clear wins over counting for as long as the key is held.
    if (clr_level) begin
      cnt_d = '0;
    end else if (step) begin
      cnt_d = dir_q ? cnt_q - CNT_W'(1) : cnt_q + CNT_W'(1);
    end
    win_d = OUT_W'(cnt_q >> shift);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running_q <= 1'b0;
      dir_q     <= 1'b0;
      cnt_q     <= '0;
      win_q     <= '0;
    end else begin
      running_q <= running_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
    end
  end

  assign led_n    = ~win_q;
  assign running  = running_q;
  assign dir_down = dir_q;

endmodule

// File: tb/tb_cnt_led_disp.sv
// tb/tb_cnt_led_disp.sv - directed self-checking bench for cnt_led_disp
module tb_cnt_led_disp;

  localparam int CNT_W  = 8;
  localparam int OUT_W  = 4;
  localparam int SEL_W  = 3;
  localparam int DB_CYC = 4;
`ifdef CNT_LED_PRESCALE_EN
  localparam int PRE_DIV = 3;
`else
  localparam int PRE_DIV = 1;
`endif

  logic             clk;
  logic             rst;
  logic             key_run_n, key_clr_n, key_dir_n;
  logic [SEL_W-1:0] sel_n;
  logic [OUT_W-1:0] led_n;
  logic             running, dir_down;

  int t;
  int n_chk;
  int n_pass;

  typedef struct packed {
    logic [2:0] sel_n;
    logic [3:0] led_n;
  } vec_t;

  vec_t vecs [8];

  cnt_led_disp #(
    .CNT_W(CNT_W), .OUT_W(OUT_W), .SEL_W(SEL_W), .DB_CYC(DB_CYC), .PRE_DIV(PRE_DIV)
  ) dut (
    .clk(clk), .rst(rst),
    .key_run_n(key_run_n), .key_clr_n(key_clr_n), .key_dir_n(key_dir_n),
    .sel_n(sel_n), .led_n(led_n), .running(running), .dir_down(dir_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      t = t + 1;
    end
  endtask

  task automatic wait_to(input int target);
    tick(target - t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
  endtask

  initial begin
    int bad;
    logic [7:0] c0, dc;
    t = 0; n_chk = 0; n_pass = 0;
    rst = 1'b0;
    key_run_n = 1'b1; key_clr_n = 1'b1; key_dir_n = 1'b1;
    sel_n = 3'b111;

    // cnt = 0xA5 frozen during the table phase
    vecs[0] = '{3'b111, 4'hA};
    vecs[1] = '{3'b110, 4'hD};
    vecs[2] = '{3'b101, 4'h6};
    vecs[3] = '{3'b100, 4'hB};
    vecs[4] = '{3'b011, 4'h5};
    vecs[5] = '{3'b010, 4'h5};
    vecs[6] = '{3'b001, 4'h5};
    vecs[7] = '{3'b000, 4'h5};

    tick(3);
    check("rst_led", 32'(led_n), 32'hF);
    check("rst_running", 32'(running), 0);
    check("rst_dir", 32'(dir_down), 0);
    rst = 1'b1;

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (dut.cnt_q !== 8'h00 || led_n !== 4'hF || running !== 1'b0) bad = bad + 1;
    end
    check("idle_hold", 32'(bad), 0);

`ifndef CNT_LED_PRESCALE_EN
    key_run_n = 1'b0;
    tick(3);
    key_run_n = 1'b1;
    tick(10);
    check("reject_short", 32'(running), 0);

    t = 0;
    key_run_n = 1'b0;
    wait_to(5);   check("run_lat_5", 32'(running), 0);
    wait_to(6);   check("run_lat_6", 32'(running), 1);
    wait_to(10);  key_run_n = 1'b1;
    wait_to(261); check("up_ff", 32'(dut.cnt_q), 32'hFF);
    check("single_pulse", 32'(running), 1);
    wait_to(262); check("up_wrap", 32'(dut.cnt_q), 32'h00);
    check("led_wrap_a", 32'(led_n), 32'h0);
    wait_to(263); check("led_wrap_b", 32'(led_n), 32'hF);

    wait_to(514); key_dir_n = 1'b0;
    wait_to(520); check("dn_02", 32'(dut.cnt_q), 32'h02);
    check("dir_set", 32'(dir_down), 1);
    wait_to(521); check("dn_01", 32'(dut.cnt_q), 32'h01);
    wait_to(522); check("dn_00", 32'(dut.cnt_q), 32'h00);
    wait_to(523); check("dn_ff", 32'(dut.cnt_q), 32'hFF);
    sel_n = 3'b000;
    wait_to(524); key_dir_n = 1'b1;
    check("clamp_win", 32'(led_n), 32'h0);

    wait_to(530); key_clr_n = 1'b0;
    wait_to(536); check("clr_before", 32'(dut.cnt_q), 32'hF2);
    wait_to(537); check("clr_zero", 32'(dut.cnt_q), 32'h00);
    wait_to(540); check("clr_running", 32'(running), 1);
    wait_to(550); key_clr_n = 1'b1;
    wait_to(556); check("clr_last", 32'(dut.cnt_q), 32'h00);
    wait_to(557); check("clr_resume", 32'(dut.cnt_q), 32'hFF);

    wait_to(560); key_clr_n = 1'b0; key_dir_n = 1'b0;
    wait_to(570); key_dir_n = 1'b1;
    check("dir_up", 32'(dir_down), 0);
    wait_to(580); key_clr_n = 1'b1;
    wait_to(587); check("up_resume", 32'(dut.cnt_q), 32'h01);
    wait_to(745); key_run_n = 1'b0;
    wait_to(755); key_run_n = 1'b1;
    wait_to(760); check("paused", 32'(running), 0);
    check("frozen_a5", 32'(dut.cnt_q), 32'hA5);

    for (int i = 0; i < 8; i++) begin
      sel_n = vecs[i].sel_n;
      tick(1);
      check($sformatf("win_sel%0d", i), 32'(led_n), 32'(vecs[i].led_n));
    end

    key_run_n = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);
    check("midrst_cnt", 32'(dut.cnt_q), 0);
    check("midrst_led", 32'(led_n), 32'hF);
    check("midrst_running", 32'(running), 0);
    rst = 1'b1;
    tick(20);
    check("held_no_pulse", 32'(running), 0);
    key_run_n = 1'b1;
    tick(10);
    check("release_no_pulse", 32'(running), 0);
    key_run_n = 1'b0;
    tick(5);
    check("repress_5", 32'(running), 0);
    tick(1);
    check("repress_6", 32'(running), 1);
    key_run_n = 1'b1;
    tick(10);
`else
    t = 0;
    key_run_n = 1'b0;
    wait_to(6);  check("pre_run", 32'(running), 1);
    wait_to(10); key_run_n = 1'b1;
    c0 = dut.cnt_q;
    tick(30);
    dc = dut.cnt_q - c0;
    check("pre_steps", 32'(dc), 10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
